// File: rtl/serializer_tx_pkg.sv
// Shared serial-link definitions for the transmitter and its deserializer.
// Default word geometry and the transmitter FSM encoding.
package serial_pkg;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam bit DEFAULT_MSB_FIRST  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/serializer_tx_if.sv
// Word-in / bit-out bundle of the serial transmitter.
// master = queue and downstream receiver side, slave = transmitter.
interface serializer_tx_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] data_in;
    logic                  data_valid_in;
    logic                  ack_out;
    logic                  status_in;
    logic                  data_out;
    logic                  write_out;
    logic                  busy_out;
    logic                  sent_out;

    modport master (
        output data_in,
        output data_valid_in,
        output status_in,
        input  ack_out,
        input  data_out,
        input  write_out,
        input  busy_out,
        input  sent_out
    );

    modport slave (
        input  data_in,
        input  data_valid_in,
        input  status_in,
        output ack_out,
        output data_out,
        output write_out,
        output busy_out,
        output sent_out
    );

endinterface

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: one word in via valid/ack,
// one bit out per cycle the receiver reports ready.
module serializer_tx
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter bit MSB_FIRST  = DEFAULT_MSB_FIRST
) (
    input logic             clock_100KHZ,
    input logic             reset,
    serializer_tx_if.slave  bus
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shreg_next;
    logic [CW-1:0]         bit_cnt;
    logic                  head;

    // Head is the bit leaving next; the register moves toward it.
    always_comb begin
        head       = 1'b0;
        shreg_next = '0;
        if (MSB_FIRST) begin
            head       = shreg[DATA_WIDTH-1];
            shreg_next = {shreg[DATA_WIDTH-2:0], 1'b0};
        end else begin
            head       = shreg[0];
            shreg_next = {1'b0, shreg[DATA_WIDTH-1:1]};
        end
    end

    assign bus.busy_out = (state != IDLE);

    always_ff @(posedge clock_100KHZ or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            shreg         <= '0;
            bit_cnt       <= '0;
            bus.ack_out   <= 1'b0;
            bus.data_out  <= 1'b0;
            bus.write_out <= 1'b0;
            bus.sent_out  <= 1'b0;
        end else begin
            bus.ack_out  <= 1'b0;
            bus.sent_out <= 1'b0;
            unique case (state)
                IDLE: begin
                    bus.write_out <= 1'b0;
                    if (bus.data_valid_in && bus.status_in) begin
                        shreg       <= bus.data_in;
                        bit_cnt     <= '0;
                        bus.ack_out <= 1'b1;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (bus.status_in) begin
                        bus.data_out  <= head;
                        bus.write_out <= 1'b1;
                        shreg         <= shreg_next;
                        bit_cnt       <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST) begin
                            state <= DONE;
                        end
                    end else begin
                        bus.write_out <= 1'b0;
                    end
                end
                DONE: begin
                    bus.write_out <= 1'b0;
                    bus.sent_out  <= 1'b1;
                    state         <= IDLE;
                end
                default: begin
                    bus.write_out <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer_tx.sv
// Directed bench for serializer_tx: MSB-first instance a,
// LSB-first instance b sharing clock and reset.
module tb_serializer_tx;

    logic clock_100KHZ;
    logic reset;
    int   errors;
    int   checks;

    serializer_tx_if #(.DATA_WIDTH(8)) a_if ();
    serializer_tx_if #(.DATA_WIDTH(8)) b_if ();

    serializer_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clock_100KHZ (clock_100KHZ),
        .reset        (reset),
        .bus          (a_if.slave)
    );

    serializer_tx #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clock_100KHZ (clock_100KHZ),
        .reset        (reset),
        .bus          (b_if.slave)
    );

    initial clock_100KHZ = 1'b0;
    always #5 clock_100KHZ = ~clock_100KHZ;

    task automatic tick();
        @(posedge clock_100KHZ);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Runs instance a until sent_out, assembling strobed bits MSB-first.
    task automatic xfer(input string tag,
                        input logic [7:0] exp_w,
                        input int exp_nb);
        logic [7:0] w;
        int nb;
        int acks;
        bit got_sent;
        w = '0;
        nb = 0;
        acks = 0;
        got_sent = 1'b0;
        for (int i = 0; i < 40 && !got_sent; i++) begin
            tick();
            if (a_if.write_out) begin
                w = {w[6:0], a_if.data_out};
                nb++;
            end
            if (a_if.ack_out) acks++;
            if (a_if.sent_out) got_sent = 1'b1;
        end
        chk({tag, "_word"}, 32'(w), 32'(exp_w));
        chk({tag, "_nbits"}, 32'(nb), 32'(exp_nb));
        chk({tag, "_acks"}, 32'(acks), 32'd0);
        chk({tag, "_sent"}, 32'(got_sent), 32'd1);
        chk({tag, "_busy"}, 32'(a_if.busy_out), 32'd0);
    endtask

    initial begin
        logic [7:0] exp_bits;
        errors = 0;
        checks = 0;
        reset = 1'b1;
        a_if.data_in = '0;
        a_if.data_valid_in = 1'b0;
        a_if.status_in = 1'b1;
        b_if.data_in = '0;
        b_if.data_valid_in = 1'b0;
        b_if.status_in = 1'b1;

        // Reset state
        tick();
        chk("rst_ack", 32'(a_if.ack_out), 0);
        chk("rst_data", 32'(a_if.data_out), 0);
        chk("rst_write", 32'(a_if.write_out), 0);
        chk("rst_busy", 32'(a_if.busy_out), 0);
        chk("rst_sent", 32'(a_if.sent_out), 0);
        reset = 1'b0;
        tick();

        // Basic send 0xA5
        a_if.data_in = 8'hA5;
        a_if.data_valid_in = 1'b1;
        tick();
        chk("a5_ack", 32'(a_if.ack_out), 1);
        chk("a5_busy", 32'(a_if.busy_out), 1);
        chk("a5_write0", 32'(a_if.write_out), 0);
        a_if.data_valid_in = 1'b0;
        exp_bits = 8'hA5;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 0) chk("a5_ack_drop", 32'(a_if.ack_out), 0);
            chk("a5_strobe", 32'(a_if.write_out), 1);
            chk("a5_bit", 32'(a_if.data_out), 32'(exp_bits[7-i]));
        end
        tick();
        chk("a5_sent", 32'(a_if.sent_out), 1);
        chk("a5_write_end", 32'(a_if.write_out), 0);
        chk("a5_busy_end", 32'(a_if.busy_out), 0);
        tick();
        chk("a5_sent_pulse", 32'(a_if.sent_out), 0);

        // Back-pressure on 0xC3 after three bits
        a_if.data_in = 8'hC3;
        a_if.data_valid_in = 1'b1;
        tick();
        chk("c3_ack", 32'(a_if.ack_out), 1);
        a_if.data_valid_in = 1'b0;
        exp_bits = 8'hC3;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("c3_strobe", 32'(a_if.write_out), 1);
            chk("c3_bit", 32'(a_if.data_out), 32'(exp_bits[7-i]));
        end
        a_if.status_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("c3_stall_wr", 32'(a_if.write_out), 0);
            chk("c3_stall_hold", 32'(a_if.data_out), 0);
            chk("c3_stall_busy", 32'(a_if.busy_out), 1);
        end
        a_if.status_in = 1'b1;
        xfer("c3_tail", 8'h03, 5);

        // Receiver not ready while idle
        a_if.data_in = 8'h3C;
        a_if.data_valid_in = 1'b1;
        a_if.status_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("nr_ack", 32'(a_if.ack_out), 0);
            chk("nr_busy", 32'(a_if.busy_out), 0);
        end
        a_if.status_in = 1'b1;
        tick();
        chk("nr_ack_go", 32'(a_if.ack_out), 1);
        chk("nr_busy_go", 32'(a_if.busy_out), 1);
        a_if.data_valid_in = 1'b0;
        xfer("nr_word", 8'h3C, 8);

        // Second word presented while busy
        a_if.data_in = 8'h96;
        a_if.data_valid_in = 1'b1;
        tick();
        chk("vb_ack1", 32'(a_if.ack_out), 1);
        a_if.data_in = 8'h5A;
        xfer("vb_first", 8'h96, 8);
        tick();
        chk("vb_ack2", 32'(a_if.ack_out), 1);
        a_if.data_valid_in = 1'b0;
        xfer("vb_second", 8'h5A, 8);

        // Reset mid-byte
        a_if.data_in = 8'hFF;
        a_if.data_valid_in = 1'b1;
        tick();
        chk("mr_ack", 32'(a_if.ack_out), 1);
        a_if.data_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mr_pre_write", 32'(a_if.write_out), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("mr_write", 32'(a_if.write_out), 0);
        chk("mr_data", 32'(a_if.data_out), 0);
        chk("mr_busy", 32'(a_if.busy_out), 0);
        chk("mr_sent", 32'(a_if.sent_out), 0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mr_no_sent", 32'(a_if.sent_out), 0);
            chk("mr_no_write", 32'(a_if.write_out), 0);
        end
        a_if.data_in = 8'h0F;
        a_if.data_valid_in = 1'b1;
        tick();
        chk("mr_next_ack", 32'(a_if.ack_out), 1);
        a_if.data_valid_in = 1'b0;
        xfer("mr_next", 8'h0F, 8);

        // LSB-first instance sends 0x01 starting with bit 0
        b_if.data_in = 8'h01;
        b_if.data_valid_in = 1'b1;
        tick();
        chk("lsb_ack", 32'(b_if.ack_out), 1);
        b_if.data_valid_in = 1'b0;
        tick();
        chk("lsb_wr0", 32'(b_if.write_out), 1);
        chk("lsb_bit0", 32'(b_if.data_out), 1);
        tick();
        chk("lsb_bit1", 32'(b_if.data_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
